// File: rtl/calc_pkg.sv
// Shared encodings for the RPN calculator: operator codes, error codes and engine states.
// Constants only; no logic, no latency.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_MOD  = 3'd3,
        OP_CLR  = 3'd4,
        OP_DROP = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_FULL      = 2'd2,
        ERR_DIV0      = 2'd3
    } err_e;

    // Bad opcode shares the all-ones code with DIV0 on the 2-bit status bus.
    localparam logic [1:0] ERR_BADOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/calc_divider.sv
// Unsigned WIDTH-bit restoring divider returning the remainder; one quotient bit per cycle.
// o_done pulses WIDTH+1 cycles after i_start; i_start while busy restarts it, no backpressure.
module calc_divider
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rem
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    // Partial remainder stays below the divisor, so the trial difference fits in WIDTH bits.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_d});
    assign w_sub   = WIDTH'(w_shift - {1'b0, r_d});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_q    <= i_dividend;
                r_d    <= i_divisor;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_ge};
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_rem  = r_rem;

endmodule

// File: rtl/rpn_calc_engine.sv
// RPN calculator on a DEPTH-entry register stack: push, ADD/SUB/MUL/CLR/DROP in 1 cycle, MOD in WIDTH+2.
// in_ready is high only when idle; tokens offered while busy are dropped, not queued.
module rpn_calc_engine
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_is_op,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [2:0]                 in_op,
    output logic [WIDTH-1:0]           a,
    output logic [WIDTH-1:0]           b,
    output logic [2:0]                 op,
    output logic [WIDTH-1:0]           result,
    output logic                       sign,
    output logic                       overflow,
    output logic [1:0]                 err,
    output logic [$clog2(DEPTH+1)-1:0] depth
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic signed [WIDTH-1:0] r_stk [DEPTH];
    logic [DW-1:0]           r_depth;
    logic [2:0]              r_op;
    logic [WIDTH-1:0]        r_result;
    logic                    r_ovf;
    logic [1:0]              r_err;
    logic                    r_a_neg;
    state_e                  r_state;
    state_e                  w_state_nxt;

    logic [IW-1:0]           w_idx_top;
    logic [IW-1:0]           w_idx_nos;
    logic [IW-1:0]           w_idx_push;
    logic                    w_has1;
    logic                    w_has2;
    logic                    w_full;
    logic signed [WIDTH-1:0] w_a;
    logic signed [WIDTH-1:0] w_b;
    logic signed [WIDTH-1:0] w_sum;
    logic signed [WIDTH-1:0] w_dif;
    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;

    logic [1:0]              w_tok_err;
    logic signed [WIDTH-1:0] w_res;
    logic                    w_res_ovf;
    logic                    w_is_arith;
    logic                    w_is_mod;
    logic                    w_div_start;
    logic                    w_div_done;
    logic [WIDTH-1:0]        w_abs_a;
    logic [WIDTH-1:0]        w_abs_b;
    logic [WIDTH-1:0]        w_rem;
    logic [WIDTH-1:0]        w_mod_res;

    assign w_has1     = (r_depth != '0);
    assign w_has2     = (r_depth >= DW'(2));
    assign w_full     = (r_depth == DW'(DEPTH));
    assign w_idx_top  = IW'(r_depth - DW'(1));
    assign w_idx_nos  = IW'(r_depth - DW'(2));
    assign w_idx_push = IW'(r_depth);

    assign w_a = w_has2 ? r_stk[w_idx_nos] : '0;
    assign w_b = w_has1 ? r_stk[w_idx_top] : '0;

    assign w_sum   = w_a + w_b;
    assign w_dif   = w_a - w_b;
    assign w_a_ext = {{WIDTH{w_a[WIDTH-1]}}, w_a};
    assign w_b_ext = {{WIDTH{w_b[WIDTH-1]}}, w_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Magnitudes are unsigned, so the most negative operand keeps its full value.
    assign w_abs_a   = w_a[WIDTH-1] ? WIDTH'(-w_a) : w_a;
    assign w_abs_b   = w_b[WIDTH-1] ? WIDTH'(-w_b) : w_b;
    assign w_mod_res = r_a_neg ? WIDTH'(~w_rem + WIDTH'(1)) : w_rem;

    always_comb begin
        w_tok_err  = ERR_NONE;
        w_res      = '0;
        w_res_ovf  = 1'b0;
        w_is_arith = 1'b0;
        w_is_mod   = 1'b0;
        if (!in_is_op) begin
            if (w_full) w_tok_err = ERR_FULL;
        end else begin
            case (in_op)
                OP_ADD, OP_SUB, OP_MUL: begin
                    if (!w_has2) begin
                        w_tok_err = ERR_UNDERFLOW;
                    end else begin
                        w_is_arith = 1'b1;
                        if (in_op == OP_ADD) begin
                            w_res     = w_sum;
                            w_res_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                                        (w_sum[WIDTH-1] != w_a[WIDTH-1]);
                        end else if (in_op == OP_SUB) begin
                            w_res     = w_dif;
                            w_res_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                                        (w_dif[WIDTH-1] != w_a[WIDTH-1]);
                        end else begin
                            w_res     = w_prod[WIDTH-1:0];
                            w_res_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
                        end
                    end
                end
                OP_MOD: begin
                    if (!w_has2)          w_tok_err = ERR_UNDERFLOW;
                    else if (w_b == '0)   w_tok_err = ERR_DIV0;
                    else                  w_is_mod  = 1'b1;
                end
                OP_CLR: ;
                OP_DROP: begin
                    if (!w_has1) w_tok_err = ERR_UNDERFLOW;
                end
                default: w_tok_err = ERR_BADOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_div_start = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && w_is_mod) begin
                    w_div_start = 1'b1;
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                if (w_div_done) w_state_nxt = WB;
            end
            WB:      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    calc_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_done     (w_div_done),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
            r_depth  <= '0;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= ERR_NONE;
            r_a_neg  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                if (in_is_op) r_op <= in_op;
                r_err <= w_tok_err;
                if (w_tok_err == ERR_NONE) begin
                    if (!in_is_op) begin
                        r_stk[w_idx_push] <= in_data;
                        r_depth           <= r_depth + DW'(1);
                    end else if (w_is_arith) begin
                        r_stk[w_idx_nos] <= w_res;
                        r_depth          <= r_depth - DW'(1);
                        r_result         <= w_res;
                        r_ovf            <= w_res_ovf;
                    end else if (w_is_mod) begin
                        r_a_neg <= w_a[WIDTH-1];
                    end else if (in_op == OP_CLR) begin
                        r_depth  <= '0;
                        r_result <= '0;
                    end else if (in_op == OP_DROP) begin
                        r_depth <= r_depth - DW'(1);
                    end
                end
            end
        end else if (r_state == WB) begin
            // Stack was frozen during the divide, so a/b still address the original operands.
            r_stk[w_idx_nos] <= w_mod_res;
            r_depth          <= r_depth - DW'(1);
            r_result         <= w_mod_res;
            r_ovf            <= 1'b0;
        end
    end

    assign a        = w_a;
    assign b        = w_b;
    assign op       = r_op;
    assign result   = r_result;
    assign sign     = r_result[WIDTH-1];
    assign overflow = r_ovf;
    assign err      = r_err;
    assign depth    = r_depth;

endmodule

// File: tb/tb_rpn_calc_engine.sv
// Bench for rpn_calc_engine (WIDTH=8, DEPTH=4): queue-based reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_rpn_calc_engine;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_is_op;
    logic [W-1:0] in_data;
    logic [2:0]   in_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] result;
    logic         sign;
    logic         overflow;
    logic [1:0]   err;
    logic [2:0]   depth;

    rpn_calc_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_is_op (in_is_op),
        .in_data  (in_data),
        .in_op    (in_op),
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (result),
        .sign     (sign),
        .overflow (overflow),
        .err      (err),
        .depth    (depth)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference model state
    int stk[$];
    int m_res, m_ovf, m_err, m_op, busy, pend;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap(int v);
        logic [W-1:0] t;
        t = W'(v);
        return int'($signed(t));
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    initial forever begin
        int x, y, full;
        @(posedge clk);
        if (rst) begin
            stk.delete();
            m_res = 0; m_ovf = 0; m_err = 0; m_op = 0; busy = 0; pend = 0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                void'(stk.pop_back());
                void'(stk.pop_back());
                stk.push_back(pend);
                m_res = pend;
                m_ovf = 0;
            end
        end else if (in_valid) begin
            if (!in_is_op) begin
                if (stk.size() == D) m_err = 2;
                else begin
                    stk.push_back(int'($signed(in_data)));
                    m_err = 0;
                end
            end else begin
                m_op = int'(in_op);
                case (int'(in_op))
                    0, 1, 2: begin
                        if (stk.size() < 2) m_err = 1;
                        else begin
                            y = stk.pop_back();
                            x = stk.pop_back();
                            full = (in_op == 3'd0) ? x + y : (in_op == 3'd1) ? x - y : x * y;
                            stk.push_back(wrap(full));
                            m_res = wrap(full);
                            m_ovf = (full != wrap(full)) ? 1 : 0;
                            m_err = 0;
                        end
                    end
                    3: begin
                        if (stk.size() < 2) m_err = 1;
                        else if (stk[stk.size()-1] == 0) m_err = 3;
                        else begin
                            pend = stk[stk.size()-2] % stk[stk.size()-1];
                            busy = W + 2;
                            m_err = 0;
                        end
                    end
                    4: begin
                        stk.delete();
                        m_res = 0;
                        m_err = 0;
                    end
                    5: begin
                        if (stk.size() == 0) m_err = 1;
                        else begin
                            void'(stk.pop_back());
                            m_err = 0;
                        end
                    end
                    default: m_err = 3;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = stk.size();
            chk("m_in_ready", int'(in_ready), (busy == 0) ? 1 : 0);
            chk("m_depth", int'(depth), n);
            chk("m_b", int'($signed(b)), (n >= 1) ? stk[n-1] : 0);
            chk("m_a", int'($signed(a)), (n >= 2) ? stk[n-2] : 0);
            chk("m_op", int'(op), m_op);
            chk("m_result", int'($signed(result)), m_res);
            chk("m_sign", int'(sign), (m_res < 0) ? 1 : 0);
            chk("m_overflow", int'(overflow), m_ovf);
            chk("m_err", int'(err), m_err);
        end
    end

    task automatic send(bit is_op, int data, int opc);
        in_valid = 1'b1;
        in_is_op = is_op;
        in_data  = W'(data);
        in_op    = 3'(opc);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push(int v);
        send(1'b0, v, 0);
    endtask

    task automatic oper(int o);
        send(1'b1, 0, o);
    endtask

    // Counts cycles with in_ready low; optionally offers junk pushes that must be ignored.
    task automatic wait_ready(input bit junk, output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            if (junk) begin
                in_valid = 1'b1;
                in_is_op = 1'b0;
                in_data  = 8'd99;
            end
            cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; in_valid = 1'b0; in_is_op = 1'b0; in_data = '0; in_op = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("rst_depth", int'(depth), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_result", int'(result), 0);
        chk("rst_op", int'(op), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        push(5); push(3); oper(0);
        chk("add_depth", int'(depth), 1);
        chk("add_b", int'($signed(b)), 8);
        chk("add_result", int'($signed(result)), 8);
        chk("add_ovf", int'(overflow), 0);
        chk("add_err", int'(err), 0);

        oper(4); push(100); push(50); oper(0);
        chk("addovf_result", int'($signed(result)), -106);
        chk("addovf_sign", int'(sign), 1);
        chk("addovf_ovf", int'(overflow), 1);
        push(-8); push(16); oper(2);
        chk("mul_result", int'($signed(result)), -128);
        chk("mul_ovf", int'(overflow), 0);
        chk("mul_a", int'($signed(a)), -106);

        oper(4); push(10); push(3); oper(1);
        chk("sub_result", int'($signed(result)), 7);
        push(-100); push(100); oper(1);
        chk("subovf_result", int'($signed(result)), 56);
        chk("subovf_ovf", int'(overflow), 1);

        oper(4); push(-7); push(3); oper(3);
        wait_ready(1'b1, cnt);
        chk("mod_busy_cycles", cnt, 10);
        chk("mod_result", int'($signed(result)), -1);
        chk("mod_depth", int'(depth), 1);
        chk("mod_ovf", int'(overflow), 0);

        oper(4); push(-7); push(0); oper(3);
        chk("div0_err", int'(err), 3);
        chk("div0_depth", int'(depth), 2);
        chk("div0_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("div0_ready2", int'(in_ready), 1);

        oper(4); push(-128); push(3); oper(3);
        wait_ready(1'b0, cnt);
        chk("modneg_result", int'($signed(result)), -2);
        push(7); push(-128); oper(3);
        wait_ready(1'b0, cnt);
        chk("modmin_result", int'($signed(result)), 7);
        chk("modmin_depth", int'(depth), 2);

        oper(4); push(1); push(2); push(3); push(4); push(5);
        chk("full_err", int'(err), 2);
        chk("full_depth", int'(depth), 4);
        chk("full_b", int'($signed(b)), 4);

        oper(4); push(9); oper(0);
        chk("under_err", int'(err), 1);
        chk("under_depth", int'(depth), 1);
        chk("under_b", int'($signed(b)), 9);
        push(2);
        chk("clear_err", int'(err), 0);

        oper(4); oper(5);
        chk("drop_empty_err", int'(err), 1);
        oper(6);
        chk("badop_err", int'(err), 3);
        chk("badop_op", int'(op), 6);
        push(1); oper(5);
        chk("drop_depth", int'(depth), 0);
        chk("drop_err", int'(err), 0);

        push(20); push(6); oper(3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_depth", int'(depth), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_ready", int'(in_ready), 1);
        chk("abort_op", int'(op), 0);
        repeat (15) @(negedge clk);
        chk("abort_no_wb", int'(depth), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
